// File: rtl/el2_dec_gpr_tmr_ctl.sv
// Triplicated decode-stage register file: majority-voted reads, optional write bypass,
// fault injection for campaigns, and a background scrubber that repairs diverged copies.
module el2_dec_gpr_tmr_ctl #(
    parameter int NREG     = 32,
    parameter int WIDTH    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rerr,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*WIDTH-1:0] wdata,
    input  logic                 inj_en,
    input  logic [1:0]           inj_copy,
    input  logic [AW-1:0]        inj_addr,
    input  logic [WIDTH-1:0]     inj_mask,
    input  logic                 scrub_en,
    output logic                 scrub_busy,
    output logic                 scrub_fix,
    output logic [15:0]          fix_cnt,
    input  logic                 scan_mode
);

    // Interfaces are unhandshaked: there is no valid/ready pair anywhere. Reads and writes
    // complete unconditionally each cycle; the scrubber only borrows idle write bandwidth
    // and simply yields (drops its fix) when a port write hits the entry it is repairing.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [AW-1:0] LAST  = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST = (ZERO_REG != 0) ? AW'(1) : '0;

    function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [WIDTH-1:0] c0 [NREG];
    logic [WIDTH-1:0] c1 [NREG];
    logic [WIDTH-1:0] c2 [NREG];

    logic [1:0]       scrub_state;
    logic [AW-1:0]    scrub_ptr;
    logic [AW-1:0]    scrub_ptr_next;
    logic [WIDTH-1:0] fix_val;
    logic             ptr_wr_hit;
    logic             fix_commit;
    logic [WIDTH-1:0] s0, s1, s2;
    logic             scrub_mis;

    logic unused_scan;
    assign unused_scan = scan_mode;

    always_comb begin
        ptr_wr_hit = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            if (wen[k] && waddr[k*AW +: AW] == scrub_ptr) begin
                ptr_wr_hit = 1'b1;
            end
        end
    end

    assign fix_commit     = (scrub_state == FIX) && !ptr_wr_hit;
    assign scrub_ptr_next = (scrub_ptr == LAST) ? FIRST : scrub_ptr + AW'(1);
    assign s0             = c0[scrub_ptr];
    assign s1             = c1[scrub_ptr];
    assign s2             = c2[scrub_ptr];
    assign scrub_mis      = (s0 != s1) || (s1 != s2);
    assign scrub_busy     = (scrub_state != IDLE);

    // Per-entry storage; later assignments take priority: injection < scrub fix < ports,
    // with higher-index ports beating lower ones.
    for (genvar i = 0; i < NREG; i++) begin : g_ent
        logic [WIDTH-1:0] q0, q1, q2;

        always_ff @(posedge clk) begin
            if (rst || (ZERO_REG != 0 && i == 0)) begin
                q0 <= '0;
                q1 <= '0;
                q2 <= '0;
            end else begin
                if (inj_en && inj_addr == AW'(i)) begin
                    if (inj_copy == 2'd0) q0 <= q0 ^ inj_mask;
                    if (inj_copy == 2'd1) q1 <= q1 ^ inj_mask;
                    if (inj_copy == 2'd2) q2 <= q2 ^ inj_mask;
                end
                if (fix_commit && scrub_ptr == AW'(i)) begin
                    q0 <= fix_val;
                    q1 <= fix_val;
                    q2 <= fix_val;
                end
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && waddr[k*AW +: AW] == AW'(i)) begin
                        q0 <= wdata[k*WIDTH +: WIDTH];
                        q1 <= wdata[k*WIDTH +: WIDTH];
                        q2 <= wdata[k*WIDTH +: WIDTH];
                    end
                end
            end
        end

        assign c0[i] = q0;
        assign c1[i] = q1;
        assign c2[i] = q2;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] v0, v1, v2;
        logic [WIDTH-1:0] d;
        logic             e;

        assign a  = raddr[p*AW +: AW];
        assign v0 = c0[a];
        assign v1 = c1[a];
        assign v2 = c2[a];

        always_comb begin
            d = vote3(v0, v1, v2);
            e = (v0 != v1) || (v1 != v2);
            if (BYPASS != 0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && waddr[k*AW +: AW] == a) begin
                        d = wdata[k*WIDTH +: WIDTH];
                        e = 1'b0;
                    end
                end
            end
            // Hardwired zero entry and out-of-range addresses win over bypass.
            if ((ZERO_REG != 0 && a == '0) || a > LAST) begin
                d = '0;
                e = 1'b0;
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = d;
        assign rerr[p]                 = e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_state <= IDLE;
            scrub_ptr   <= FIRST;
            fix_val     <= '0;
            scrub_fix   <= 1'b0;
            fix_cnt     <= '0;
        end else begin
            scrub_fix <= 1'b0;
            case (scrub_state)
                IDLE: begin
                    if (scrub_en) scrub_state <= SCAN;
                end
                SCAN: begin
                    if (!scrub_en) begin
                        scrub_state <= IDLE;
                    end else if (scrub_mis) begin
                        fix_val     <= vote3(s0, s1, s2);
                        scrub_state <= FIX;
                    end else begin
                        scrub_ptr <= scrub_ptr_next;
                    end
                end
                FIX: begin
                    scrub_ptr   <= scrub_ptr_next;
                    scrub_state <= scrub_en ? SCAN : IDLE;
                    if (fix_commit) begin
                        scrub_fix <= 1'b1;
                        if (fix_cnt != 16'hFFFF) fix_cnt <= fix_cnt + 16'd1;
                    end
                end
                default: scrub_state <= IDLE;
            endcase
        end
    end

endmodule
